uart_tx_frame_arbiter: RTL and testbench

- Shares the single UART transmit port (wr_uart / data_in / tx_full) between NUM_REQ frame producers, e.g. the command-response path and an asynchronous event/error reporter.
- Each requester supplies one command byte and one data byte.
- The block emits the complete frame SFD, cmd, data, EFD atomically into the UART TX FIFO, so frames from different requesters never interleave.
- Arbitration is round-robin at frame granularity.

---
 rtl/uart_tx_frame_arbiter_pkg.sv | 37 +++
 rtl/uart_tx_frame_arbiter_if.sv | 30 +++
 rtl/uart_tx_frame_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_frame_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_frame_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared constants and types for the UART TX frame arbiter.
// Frame layout on the wire: SFD, cmd, data, EFD. The byte constants match
// the receive-side comm layer, so both ends agree on framing.
package uart_tx_frame_arbiter_pkg;

    localparam logic [7:0] SFD_BYTE = 8'hAA;
    localparam logic [7:0] EFD_BYTE = 8'hED;
    localparam logic [7:0] ERR_BYTE = 8'hEE;
    localparam logic [7:0] WTM_BYTE = 8'hF4;

    // Byte position within a frame
    localparam logic [1:0] IDX_SFD  = 2'd0;
    localparam logic [1:0] IDX_CMD  = 2'd1;
    localparam logic [1:0] IDX_DATA = 2'd2;
    localparam logic [1:0] IDX_EFD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Byte emitted at frame position idx
    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [7:0] sfd,
                                              input logic [7:0] cmd,
                                              input logic [7:0] data,
                                              input logic [7:0] efd);
        case (idx)
            IDX_SFD:  return sfd;
            IDX_CMD:  return cmd;
            IDX_DATA: return data;
            default:  return efd;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_if.sv
// Bus bundle between the frame producers / UART TX FIFO and the arbiter.
//   req/req_cmd/req_data : producer requests (packed, 8 bits per requester)
//   gnt/done             : per-requester one-cycle pulses
//   busy                 : frame in progress
//   tx_full              : UART TX FIFO full
//   wr_uart/data_in      : UART TX FIFO write port
// slave = arbiter side, master = producers + FIFO side.
interface uart_tx_frame_arbiter_if #(parameter int NUM_REQ = 2);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_cmd;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 tx_full;
    logic                 wr_uart;
    logic [7:0]           data_in;

    modport master (
        output req, req_cmd, req_data, tx_full,
        input  gnt, done, busy, wr_uart, data_in
    );

    modport slave (
        input  req, req_cmd, req_data, tx_full,
        output gnt, done, busy, wr_uart, data_in
    );

endinterface

// File: rtl/uart_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin select.
//   req    : request vector
//   ptr    : index of the last winner; search starts at ptr+1 and wraps
//   valid  : any request present
//   winner : first set index found
module uart_tx_frame_arbiter_rr_pick
    import uart_tx_frame_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      winner
);

    int j;

    // Scan from the farthest candidate to the nearest so the nearest set
    // bit after ptr is the last one assigned.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                valid  = 1'b1;
                winner = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one UART TX FIFO write port between NUM_REQ frame producers.
// Each granted requester gets a complete SFD/cmd/data/EFD frame written
// atomically; arbitration is round-robin per frame.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of uart_tx_frame_arbiter_if (requests, gnt/done,
//           busy, UART write port and tx_full)
module uart_tx_frame_arbiter
    import uart_tx_frame_arbiter_pkg::*;
#(
    parameter int         NUM_REQ = 2,
    parameter logic [7:0] SFD     = SFD_BYTE,
    parameter logic [7:0] EFD     = EFD_BYTE
) (
    input  logic                       clock,
    input  logic                       reset,
    uart_tx_frame_arbiter_if.slave     bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_n;
    logic [IW-1:0]      ptr, ptr_n, owner, owner_n, pick_win;
    logic               pick_vld;
    logic [1:0]         idx, idx_n;
    logic [7:0]         cap_cmd, cap_cmd_n, cap_data, cap_data_n;
    logic [7:0]         data_in_q, data_in_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n, done_q, done_n;
    logic               wr_q, wr_n;

    uart_tx_frame_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        idx_n      = idx;
        cap_cmd_n  = cap_cmd;
        cap_data_n = cap_data;
        data_in_n  = data_in_q;
        gnt_n      = '0;
        done_n     = '0;
        wr_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    // Bytes are frozen here; later req_cmd/req_data changes
                    // only affect the requester's next frame.
                    cap_cmd_n       = bus.req_cmd[{pick_win, 3'b000} +: 8];
                    cap_data_n      = bus.req_data[{pick_win, 3'b000} +: 8];
                    owner_n         = pick_win;
                    ptr_n           = pick_win;
                    idx_n           = IDX_SFD;
                    gnt_n[pick_win] = 1'b1;
                    state_n         = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus.tx_full) begin
                    wr_n      = 1'b1;
                    data_in_n = frame_byte(idx, SFD, cap_cmd, cap_data, EFD);
                    state_n   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Gap cycle: lets tx_full reflect this write before the
                // next byte is considered.
                if (idx == IDX_EFD) begin
                    done_n[owner] = 1'b1;
                    state_n       = ST_IDLE;
                end else begin
                    idx_n   = idx + 2'd1;
                    state_n = ST_SEND;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            owner     <= '0;
            idx       <= '0;
            cap_cmd   <= '0;
            cap_data  <= '0;
            data_in_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            wr_q      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            idx       <= idx_n;
            cap_cmd   <= cap_cmd_n;
            cap_data  <= cap_data_n;
            data_in_q <= data_in_n;
            gnt_q     <= gnt_n;
            done_q    <= done_n;
            wr_q      <= wr_n;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.wr_uart = wr_q;
    assign bus.data_in = data_in_q;
    assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter with a frame-level model
// checked every cycle, plus literal latency/byte-stream expectations.
module tb_uart_tx_frame_arbiter;

    localparam int N = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_tx_frame_arbiter_if #(.NUM_REQ(N)) bus ();
    uart_tx_frame_arbiter #(.NUM_REQ(N)) dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    int         wr_cyc[$];
    logic [7:0] wr_byte[$];
    int         gnt_cyc[$];
    int         gnt_who[$];
    int         done_cyc[$];
    logic [7:0] exp_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model: frame-level view ----------------
    logic [N-1:0] e_gnt, e_done;
    logic         e_wr, e_busy;
    logic [7:0]   e_din;
    logic [7:0]   m_frame[4];
    int           m_pos, m_ptr, m_owner, m_win;
    bit           m_ready;

    initial begin
        e_gnt = '0; e_done = '0; e_wr = 1'b0; e_busy = 1'b0; e_din = '0;
        m_pos = 0; m_ptr = N - 1; m_owner = 0; m_ready = 1'b0;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                e_gnt = '0; e_done = '0; e_wr = 1'b0; e_busy = 1'b0; e_din = '0;
                m_pos = 0; m_ptr = N - 1; m_owner = 0; m_ready = 1'b0;
            end else begin
                e_gnt = '0; e_done = '0; e_wr = 1'b0;
                if (!e_busy) begin
                    m_win = -1;
                    for (int k = 1; k <= N; k++)
                        if (m_win < 0 && bus.req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                    if (m_win >= 0) begin
                        m_frame[0] = 8'hAA;
                        m_frame[1] = bus.req_cmd[8*m_win +: 8];
                        m_frame[2] = bus.req_data[8*m_win +: 8];
                        m_frame[3] = 8'hED;
                        e_gnt[m_win] = 1'b1;
                        m_ptr = m_win; m_owner = m_win;
                        e_busy = 1'b1; m_pos = 0; m_ready = 1'b1;
                    end
                end else if (m_ready) begin
                    if (!bus.tx_full) begin
                        e_wr = 1'b1; e_din = m_frame[m_pos];
                        m_pos++; m_ready = 1'b0;
                    end
                end else begin
                    if (m_pos == 4) begin
                        e_done[m_owner] = 1'b1; e_busy = 1'b0;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // ---------------- per-cycle compare + event log ----------------
    initial forever begin
        @(negedge clock);
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("wr_uart", 32'(bus.wr_uart), 32'(e_wr));
        chk("data_in", 32'(bus.data_in), 32'(e_din));
        chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
        chk("done_onehot", 32'($onehot0(bus.done)), 32'd1);
        if (bus.wr_uart) begin wr_cyc.push_back(cyc); wr_byte.push_back(bus.data_in); end
        if (bus.gnt != '0) begin gnt_cyc.push_back(cyc); gnt_who.push_back($clog2(bus.gnt)); end
        if (bus.done != '0) done_cyc.push_back(cyc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic clr_logs();
        wr_cyc.delete(); wr_byte.delete(); gnt_cyc.delete(); gnt_who.delete(); done_cyc.delete();
    endtask

    // Wait for n grants; requesters in drop_mask release req the cycle after their grant.
    task automatic wait_grants(input int n, input logic [N-1:0] drop_mask);
        int budget;
        int h;
        budget = 300;
        h = 0;
        while (gnt_who.size() < n && budget > 0) begin
            step(1);
            budget--;
            while (h < gnt_who.size()) begin
                if (drop_mask[gnt_who[h]]) bus.req[gnt_who[h]] = 1'b0;
                h++;
            end
        end
        chk("grants_seen", 32'(gnt_who.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int budget;
        budget = 100;
        while (bus.busy && budget > 0) begin
            step(1);
            budget--;
        end
        chk("idle_reached", 32'(bus.busy), 32'd0);
        step(2);
    endtask

    task automatic chk_stream(input string nm);
        chk({nm, "_len"}, 32'(wr_byte.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < wr_byte.size(); i++)
            chk(nm, 32'(wr_byte[i]), 32'(exp_b[i]));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.req = '0; bus.req_cmd = '0; bus.req_data = '0; bus.tx_full = 1'b0;
        reset = 1'b0;
        step(3);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wr", 32'(bus.wr_uart), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_data_in", 32'(bus.data_in), 32'd0);
        reset = 1'b1;
        step(2);

        // 1: single uncontended frame, latency pinned
        clr_logs();
        bus.req_cmd[7:0] = 8'hF4; bus.req_data[7:0] = 8'h5A; bus.req = 2'b01;
        t0 = cyc;
        wait_grants(1, 2'b11);
        wait_idle();
        chk("t1_gnt_cyc", 32'(gnt_cyc[0]), 32'(t0 + 1));
        chk("t1_gnt_who", 32'(gnt_who[0]), 32'd0);
        chk("t1_wr_cnt", 32'(wr_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++)
            chk("t1_wr_cyc", 32'(wr_cyc[i]), 32'(t0 + 2 + 2 * i));
        exp_b = '{8'hAA, 8'hF4, 8'h5A, 8'hED};
        chk_stream("t1_bytes");
        chk("t1_done_cyc", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'(t0 + 9));

        // 2: both request after reset, back-to-back frames
        reset = 1'b0; step(1); reset = 1'b1; step(1);
        clr_logs();
        bus.req_cmd = {8'h02, 8'h01}; bus.req_data = {8'h22, 8'h11}; bus.req = 2'b11;
        t0 = cyc;
        wait_grants(2, 2'b11);
        wait_idle();
        exp_b = '{8'hAA, 8'h01, 8'h11, 8'hED, 8'hAA, 8'h02, 8'h22, 8'hED};
        chk_stream("t2_bytes");
        chk("t2_gnt1_cyc", 32'(gnt_cyc[1]), 32'(t0 + 10));
        chk("t2_sfd2_cyc", 32'(wr_cyc.size() > 4 ? wr_cyc[4] : -1), 32'(t0 + 11));
        chk("t2_order0", 32'(gnt_who[0]), 32'd0);
        chk("t2_order1", 32'(gnt_who[1]), 32'd1);

        // 3: both held for four frames -> 0,1,0,1 at 9-cycle spacing
        clr_logs();
        bus.req = 2'b11;
        wait_grants(4, 2'b00);
        bus.req = 2'b00;
        wait_idle();
        for (int i = 0; i < 4 && i < gnt_who.size(); i++)
            chk("t3_order", 32'(gnt_who[i]), 32'(i % 2));
        for (int i = 1; i < 4 && i < gnt_cyc.size(); i++)
            chk("t3_period", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd9);

        // 4: tx_full stall from SEND of the cmd byte for 5 cycles
        clr_logs();
        bus.req_cmd[7:0] = 8'hC3; bus.req_data[7:0] = 8'h3C; bus.req = 2'b01;
        t0 = cyc;
        step(1); bus.req = 2'b00;
        step(2); bus.tx_full = 1'b1;
        step(5); bus.tx_full = 1'b0;
        wait_idle();
        exp_b = '{8'hAA, 8'hC3, 8'h3C, 8'hED};
        chk_stream("t4_bytes");
        chk("t4_wr_cnt", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4) begin
            chk("t4_wr0", 32'(wr_cyc[0]), 32'(t0 + 2));
            chk("t4_wr1", 32'(wr_cyc[1]), 32'(t0 + 9));
            chk("t4_wr2", 32'(wr_cyc[2]), 32'(t0 + 11));
            chk("t4_wr3", 32'(wr_cyc[3]), 32'(t0 + 13));
        end
        chk("t4_done_cyc", 32'(done_cyc.size() > 0 ? done_cyc[0] : -1), 32'(t0 + 14));

        // 5: reset in WAIT after the data byte; then priority restarts at 0
        clr_logs();
        bus.req_cmd[7:0] = 8'h77; bus.req_data[7:0] = 8'h88; bus.req = 2'b01;
        t0 = cyc;
        step(1); bus.req = 2'b00;
        step(5);
        reset = 1'b0;
        #1;
        chk("t5_rst_wr", 32'(bus.wr_uart), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        step(2);
        reset = 1'b1;
        exp_b = '{8'hAA, 8'h77};
        chk_stream("t5_partial");
        chk("t5_no_done", 32'(done_cyc.size()), 32'd0);
        step(1);
        clr_logs();
        bus.req = 2'b11;
        wait_grants(2, 2'b11);
        wait_idle();
        chk("t5_first_after_rst", 32'(gnt_who[0]), 32'd0);
        chk("t5_second_after_rst", 32'(gnt_who[1]), 32'd1);

        // 6: cmd changed after grant only shows up in the next frame
        clr_logs();
        bus.req_cmd = {8'h02, 8'h44}; bus.req_data = {8'h22, 8'h66}; bus.req = 2'b01;
        step(1);
        bus.req_cmd[7:0] = 8'h33;
        wait_grants(2, 2'b00);
        bus.req = 2'b00;
        wait_idle();
        exp_b = '{8'hAA, 8'h44, 8'h66, 8'hED, 8'hAA, 8'h33, 8'h66, 8'hED};
        chk_stream("t6_bytes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
